// File: rtl/read_sched_if.sv
// Read-scheduler bundle: per-master AR request signals, the shared handshake
// qualifiers, and the scheduler's grant/enable/status outputs.
interface read_sched_if #(
    parameter int LEN_W = 4
);
    // Requests from the two masters
    logic             arvalid_m0;
    logic             arvalid_m1;
    logic [LEN_W-1:0] arlen_m0;
    logic [LEN_W-1:0] arlen_m1;

    // Handshake qualifiers observed on the granted path
    logic             ar_hs;
    logic             r_hs;
    logic             rlast;

    // Scheduler outputs
    logic             grant_m0;
    logic             grant_m1;
    logic             ar_en;
    logic             r_en;
    logic             busy;
    logic [LEN_W:0]   beats_left;
    logic             len_err;
    logic             timeout;

    // Scheduler side
    modport slave (
        input  arvalid_m0, arvalid_m1, arlen_m0, arlen_m1,
        input  ar_hs, r_hs, rlast,
        output grant_m0, grant_m1, ar_en, r_en, busy,
        output beats_left, len_err, timeout
    );

    // Requester / fabric side
    modport master (
        output arvalid_m0, arvalid_m1, arlen_m0, arlen_m1,
        output ar_hs, r_hs, rlast,
        input  grant_m0, grant_m1, ar_en, r_en, busy,
        input  beats_left, len_err, timeout
    );
endinterface

// File: rtl/read_sched.sv
// Read-transaction scheduler: round-robin AR arbitration between M0 and M1,
// grant held through the address handshake, then the read path is reserved
// until the burst's last R beat (or a watchdog abort). One read in flight.
module read_sched #(
    parameter int LEN_W   = 4,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    read_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);
    localparam logic [LEN_W:0]  BEAT_ONE  = (LEN_W+1)'(1);

    state_t            state, state_nxt;
    logic              last, last_nxt;        // 0: M0 was the most recent grant
    logic [TO_W-1:0]   wd, wd_nxt;            // idle-cycle watchdog in DATA
    logic              grant_m0_q, grant_m0_nxt;
    logic              grant_m1_q, grant_m1_nxt;
    logic [LEN_W:0]    beats_q, beats_nxt;
    logic              len_err_q, len_err_nxt;
    logic              timeout_q, timeout_nxt;
    logic [LEN_W-1:0]  sel_len;

    // Burst length of whichever master currently holds the grant
    assign sel_len = grant_m1_q ? bus.arlen_m1 : bus.arlen_m0;

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values computed by the comb block.
        if (rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            wd         <= '0;
            grant_m0_q <= 1'b0;
            grant_m1_q <= 1'b0;
            beats_q    <= '0;
            len_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            wd         <= wd_nxt;
            grant_m0_q <= grant_m0_nxt;
            grant_m1_q <= grant_m1_nxt;
            beats_q    <= beats_nxt;
            len_err_q  <= len_err_nxt;
            timeout_q  <= timeout_nxt;
        end
    end

    // Next-state, arbitration, beat accounting and watchdog
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_nxt    = state;
        last_nxt     = last;
        wd_nxt       = wd;
        grant_m0_nxt = grant_m0_q;
        grant_m1_nxt = grant_m1_q;
        beats_nxt    = beats_q;
        len_err_nxt  = 1'b0;
        timeout_nxt  = 1'b0;

        case (state)
            IDLE: begin
                grant_m0_nxt = 1'b0;
                grant_m1_nxt = 1'b0;
                beats_nxt    = '0;
                wd_nxt       = '0;
                // On a tie the master that was not granted last wins
                if (bus.arvalid_m0 && (!bus.arvalid_m1 || last)) begin
                    grant_m0_nxt = 1'b1;
                    last_nxt     = 1'b0;
                    state_nxt    = ADDR;
                end else if (bus.arvalid_m1) begin
                    grant_m1_nxt = 1'b1;
                    last_nxt     = 1'b1;
                    state_nxt    = ADDR;
                end
            end

            ADDR: begin
                // Grant is held even if arvalid drops; only ar_hs moves on
                if (bus.ar_hs) begin
                    beats_nxt = {1'b0, sel_len} + BEAT_ONE;
                    wd_nxt    = '0;
                    state_nxt = DATA;
                end
            end

            DATA: begin
                if (bus.r_hs) begin
                    wd_nxt = '0;
                    if (bus.rlast) begin
                        // RLAST ends the burst; early RLAST is flagged
                        len_err_nxt  = (beats_q > BEAT_ONE);
                        state_nxt    = IDLE;
                        grant_m0_nxt = 1'b0;
                        grant_m1_nxt = 1'b0;
                        beats_nxt    = '0;
                    end else if (beats_q == BEAT_ONE) begin
                        // Expected last beat without RLAST: flag once, wait
                        len_err_nxt = 1'b1;
                        beats_nxt   = '0;
                    end else if (beats_q != '0) begin
                        beats_nxt = beats_q - BEAT_ONE;
                    end
                end else if (wd == TIMEOUT_C) begin
                    // Silent slave: abort and free the read path
                    timeout_nxt  = 1'b1;
                    state_nxt    = IDLE;
                    grant_m0_nxt = 1'b0;
                    grant_m1_nxt = 1'b0;
                    beats_nxt    = '0;
                    wd_nxt       = '0;
                end else begin
                    wd_nxt = wd + TO_W'(1);
                end
            end

            default: begin
                state_nxt    = IDLE;
                grant_m0_nxt = 1'b0;
                grant_m1_nxt = 1'b0;
                beats_nxt    = '0;
                wd_nxt       = '0;
            end
        endcase
    end

    // Outputs: registered values plus state decodes for the mux enables
    assign bus.grant_m0   = grant_m0_q;
    assign bus.grant_m1   = grant_m1_q;
    assign bus.beats_left = beats_q;
    assign bus.len_err    = len_err_q;
    assign bus.timeout    = timeout_q;
    assign bus.ar_en      = (state == ADDR);
    assign bus.r_en       = (state == DATA);
    assign bus.busy       = (state != IDLE);

endmodule

// File: doc/read_sched.md
# read_sched

Read-transaction scheduler for the AXI read path. It arbitrates AR requests from master M0 (CPU instruction port) and master M1 (CPU data port) with round-robin fairness, and holds the grant until the address handshake. It then keeps the read path reserved until the burst's R beats complete, so the read interconnect carries exactly one outstanding read at a time. Its grant and enable outputs drive the mux selects of the read address channel and the read data channel.

## Interface
- LEN_W, 4, AXI ARLEN width
- TO_W, 8, watchdog counter width
- TIMEOUT, 255, idle cycles allowed in DATA before abort (must fit TO_W)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- arvalid_m0  in  1  M0 ARVALID
- arvalid_m1  in  1  M1 ARVALID
- arlen_m0  in  LEN_W  M0 ARLEN
- arlen_m1  in  LEN_W  M1 ARLEN
- ar_hs  in  1  ARVALID&ARREADY of the granted request at the selected slave
- r_hs  in  1  RVALID&RREADY on the granted master's R channel
- rlast  in  1  RLAST qualifying r_hs
- grant_m0  out  1  M0 owns the read path
- grant_m1  out  1  M1 owns the read path
- ar_en  out  1  AR mux enabled (state ADDR)
- r_en  out  1  R mux enabled (state DATA)
- busy  out  1  state != IDLE
- beats_left  out  LEN_W+1  remaining expected R beats
- len_err  out  1  one-cycle pulse: RLAST position mismatch
- timeout  out  1  one-cycle pulse: watchdog abort

## Operation
- States: IDLE, ADDR, DATA. All outputs registered, except that ar_en, r_en and busy decode the state register.
- Priority pointer `last`: 0 means M0 was the most recent grant. On reset `last`=1, so M0 wins the first tie.
- IDLE: no request -> stay. Only one arvalid -> grant that master. Both asserted -> grant the master != `last`. Next state ADDR. `last` updates to the granted master.
- ADDR: grant held. ar_hs -> capture the granted master's arlen, load beats_left = arlen+1 (range 1..2^LEN_W, hence LEN_W+1 bits), clear the watchdog, next state DATA.
  - An arvalid drop while in ADDR does not abort; the grant is held until ar_hs.
- DATA, on each r_hs:
  - rlast and beats_left==1 -> normal end; next state IDLE; grants cleared; beats_left=0.
  - rlast and beats_left>1 -> len_err pulse; end as above.
  - ~rlast and beats_left==1 -> len_err pulse; beats_left saturates at 0; stay in DATA until rlast.
  - ~rlast and beats_left==0 -> no further len_err; stay in DATA.
  - ~rlast otherwise -> decrement beats_left.
- Watchdog:
  - It increments on every DATA cycle without r_hs, and clears on r_hs.
  - When it reaches TIMEOUT: timeout pulse, next state IDLE, grants cleared, beats_left=0.
- Reset at any point: state IDLE, all outputs 0, `last`=1, watchdog 0. An in-flight burst is dropped without a pulse.

## Timing
- Reset values: grant_m0=grant_m1=ar_en=r_en=busy=len_err=timeout=0, beats_left=0.
- The cycle after arvalid is sampled in IDLE: grant and ar_en are high.
- The cycle after ar_hs: r_en high, beats_left valid.
- Final beat: r_hs&rlast in cycle N -> IDLE at N+1 with grants low. The earliest next grant is at N+2.
  - Minimum turnaround is one IDLE cycle; back-to-back grants never occur.
- len_err and timeout are high for exactly the cycle after the triggering event.
- Watchdog timing: with TIMEOUT=T and no r_hs, timeout asserts T+1 cycles after entering DATA.
- Simultaneous r_hs&rlast and watchdog hitting TIMEOUT in the same cycle: normal end wins and timeout stays low.
- Grant exclusivity: grant_m0&grant_m1 is never 1.

## Test plan
- Single M0 read, arlen=3:
  - arvalid_m0 at cycle 0 -> grant_m0 at cycle 1.
  - ar_hs at cycle 2 -> beats_left=4.
  - 4 r_hs, last beat with rlast -> IDLE, len_err=0.
- Contention: both arvalid held for 4 transactions of arlen=0 -> grant order M0, M1, M0, M1, each separated by one IDLE cycle.
- Early RLAST: arlen=3, rlast on the 2nd beat -> len_err pulse, IDLE next cycle.
- Late RLAST: arlen=1, rlast on the 4th beat:
  - len_err pulses once, after the 2nd beat; beats_left stays 0.
  - End on the 4th beat.
- Watchdog: TIMEOUT=8, no r_hs after ar_hs -> timeout pulse 9 cycles after DATA entry, grants cleared. Repeat with rlast arriving in that same cycle -> no timeout.
- Reset mid-burst: assert rst in DATA with beats_left=2 -> next cycle all outputs 0. Then both masters request -> M0 granted first.
